// File: rtl/tx_frame_controller.sv
// Byte-wide TX frame sequencer: header, payload, CRC-8 trailer, then ACK/NACK wait
// with bounded retransmission and a per-attempt timeout.
module tx_frame_controller #(
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [7:0]  CRC_POLY    = 8'h07
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [135:0] i_tx_packet,
  input  logic         i_test_mode,
  output logic [7:0]   o_tx_data,
  output logic         o_tx_valid,
  input  logic         i_tx_ready,
  input  logic         i_rx_ack,
  input  logic         i_rx_nack,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_fail,
  output logic [1:0]   o_retry_cnt
);

  localparam logic [7:0] TimeoutLast = 8'(ACK_TIMEOUT - 1);
  localparam logic [1:0] MaxRetry    = 2'(MAX_RETRY);

  typedef enum logic [2:0] {StIdle, StHdr, StPay, StCrc, StWaitAck} state_e;

  state_e       r_state;
  logic [135:0] r_pkt;
  logic         r_tmode;
  logic [7:0]   r_crc;
  logic [3:0]   r_idx;
  logic [7:0]   r_timer;
  logic [1:0]   r_retry;
  logic [7:0]   r_tx_data;
  logic         r_tx_valid;
  logic         r_busy;
  logic         r_done;
  logic         r_fail;

  logic [7:0]   w_crc_next;
  logic [3:0]   w_len;
  logic [3:0]   w_idx_nxt;
  logic [7:0]   w_pay_byte;
  logic         w_retry_req;

  // CRC folded over the byte currently on the link; only committed on a transfer.
  always_comb begin
    w_crc_next = r_crc ^ r_tx_data;
    for (int i = 0; i < 8; i++) begin
      w_crc_next = w_crc_next[7] ? ((w_crc_next << 1) ^ CRC_POLY) : (w_crc_next << 1);
    end
  end

  assign w_len       = r_pkt[131:128];
  assign w_idx_nxt   = r_idx + 4'd1;
  assign w_pay_byte  = r_pkt[8'd127 - {1'b0, w_idx_nxt, 3'b000} -: 8];
  assign w_retry_req = i_rx_nack || (!i_rx_ack && (r_timer == TimeoutLast));

  // tx_data is loaded one edge early so consecutive bytes go out with no bubble.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pkt      <= '0;
      r_tmode    <= 1'b0;
      r_crc      <= 8'h00;
      r_idx      <= 4'd0;
      r_timer    <= 8'd0;
      r_retry    <= 2'd0;
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fail     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_fail <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_pkt      <= i_tx_packet;
            r_tmode    <= i_test_mode;
            r_retry    <= 2'd0;
            r_crc      <= 8'h00;
            r_idx      <= 4'd0;
            r_tx_data  <= i_tx_packet[135:128];
            r_tx_valid <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StHdr;
          end
        end
        StHdr: begin
          if (i_tx_ready) begin
            r_crc <= w_crc_next;
            r_idx <= 4'd0;
            if (w_len == 4'd0) begin
              r_tx_data <= w_crc_next ^ {7'b0, r_tmode};
              r_state   <= StCrc;
            end else begin
              r_tx_data <= r_pkt[127:120];
              r_state   <= StPay;
            end
          end
        end
        StPay: begin
          if (i_tx_ready) begin
            r_crc <= w_crc_next;
            r_idx <= w_idx_nxt;
            if (w_idx_nxt == w_len) begin
              r_tx_data <= w_crc_next ^ {7'b0, r_tmode};
              r_state   <= StCrc;
            end else begin
              r_tx_data <= w_pay_byte;
            end
          end
        end
        StCrc: begin
          if (i_tx_ready) begin
            r_timer    <= 8'd0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
            r_state    <= StWaitAck;
          end
        end
        StWaitAck: begin
          r_timer <= r_timer + 8'd1;
          if (w_retry_req) begin
            if (r_retry < MaxRetry) begin
              r_retry    <= r_retry + 2'd1;
              r_crc      <= 8'h00;
              r_idx      <= 4'd0;
              r_tx_data  <= r_pkt[135:128];
              r_tx_valid <= 1'b1;
              r_state    <= StHdr;
            end else begin
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
              r_state <= StIdle;
            end
          end else if (i_rx_ack) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        default: begin
          r_state    <= StIdle;
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_fail      = r_fail;
  assign o_retry_cnt = r_retry;

endmodule

// File: tb/tb_tx_frame_controller.sv
// Bench for tx_frame_controller: table of ACKed frames plus hand sequences for
// stalls, retries/timeout and mid-frame reset; link bytes checked against a queue.
module tb_tx_frame_controller;

  logic         clk = 1'b0;
  logic         i_rst, i_start, i_test_mode, i_tx_ready, i_rx_ack, i_rx_nack;
  logic [135:0] i_tx_packet;
  logic [7:0]   o_tx_data;
  logic         o_tx_valid, o_busy, o_done, o_fail;
  logic [1:0]   o_retry_cnt;

  int total = 0, bad = 0, xfers = 0, done_cnt = 0, fail_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;

  typedef struct {
    logic [135:0] pkt;
    logic         tmode;
    logic         use_model;
    logic [7:0]   crc;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  tx_frame_controller dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_tx_packet (i_tx_packet),
    .i_test_mode (i_test_mode),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .i_rx_ack    (i_rx_ack),
    .i_rx_nack   (i_rx_nack),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_fail      (o_fail),
    .o_retry_cnt (o_retry_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
    logic [7:0] x;
    x = c ^ b;
    for (int i = 0; i < 8; i++) x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  function automatic logic [7:0] model_crc(input logic [135:0] pkt);
    logic [7:0] c;
    c = crc8_upd(8'h00, pkt[135:128]);
    for (int i = 0; i < int'(pkt[131:128]); i++) c = crc8_upd(c, pkt[127 - 8*i -: 8]);
    return c;
  endfunction

  // Link monitor: sampled mid-cycle, a byte transfers at the next rising edge.
  always @(negedge clk) begin
    if (o_done) done_cnt++;
    if (o_fail) fail_cnt++;
    if (o_done || o_fail) chk("done_fail_excl", 32'(o_done & o_fail), 32'd0);
    if (stall_prev && !i_rst) chk("hold_while_stalled", 32'(o_tx_data), 32'(stall_data));
    if (o_tx_valid && i_tx_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        chk("unexpected_byte", 32'(o_tx_data), 32'h100);
      end else begin
        mon_exp = exp_q.pop_front();
        chk($sformatf("byte#%0d", xfers), 32'(o_tx_data), 32'(mon_exp));
      end
    end
    stall_prev = o_tx_valid && !i_tx_ready && !i_rst;
    stall_data = o_tx_data;
  end

  task automatic push_frame(input logic [135:0] pkt, input logic [7:0] crc_byte);
    exp_q.push_back(pkt[135:128]);
    for (int i = 0; i < int'(pkt[131:128]); i++) exp_q.push_back(pkt[127 - 8*i -: 8]);
    exp_q.push_back(crc_byte);
  endtask

  task automatic pulse_start(input logic [135:0] pkt, input logic tmode);
    i_tx_packet = pkt;
    i_test_mode = tmode;
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_tx(input int budget, input bit toggle, output int n);
    n = 0;
    while ((exp_q.size() != 0 || o_tx_valid) && n < budget) begin
      if (toggle) i_tx_ready = ~i_tx_ready;
      tick();
      n++;
    end
    if (n >= budget) begin
      total++;
      bad++;
      $display("FAIL tx_wait_expired: %0d bytes still pending after %0d cycles",
               exp_q.size(), n);
    end
  endtask

  task automatic ack_check(input string nm, input logic [1:0] exp_retry);
    tick();
    i_rx_ack = 1'b1;
    tick();
    i_rx_ack = 1'b0;
    chk({nm, "_done"}, 32'(o_done), 32'd1);
    chk({nm, "_busy"}, 32'(o_busy), 32'd0);
    chk({nm, "_fail"}, 32'(o_fail), 32'd0);
    chk({nm, "_retry"}, 32'(o_retry_cnt), 32'(exp_retry));
    tick();
    chk({nm, "_done_pulse"}, 32'(o_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d0, f0, x0;
    logic [7:0] crc;
    i_rst = 1'b1; i_start = 1'b0; i_test_mode = 1'b0; i_tx_ready = 1'b1;
    i_rx_ack = 1'b0; i_rx_nack = 1'b0; i_tx_packet = '0;
    repeat (2) tick();
    chk("rst_valid", 32'(o_tx_valid), 32'd0);
    chk("rst_data", 32'(o_tx_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_fail", 32'(o_fail), 32'd0);
    chk("rst_retry", 32'(o_retry_cnt), 32'd0);
    i_rst = 1'b0;
    tick();

    vecs[0] = '{{8'h01, 8'h00, {15{8'hA5}}}, 1'b0, 1'b0, 8'h15};
    vecs[1] = '{{8'h01, 8'h00, {15{8'hA5}}}, 1'b1, 1'b0, 8'h14};
    vecs[2] = '{{8'hC3, 128'hDEADBEEF_01234567_89ABCDEF_55AA33CC}, 1'b0, 1'b1, 8'h00};
    vecs[3] = '{{8'h00, {16{8'h5A}}}, 1'b0, 1'b0, 8'h00};
    vecs[4] = '{{8'h4F, 128'h00010203_04050607_08090A0B_0C0D0EFF}, 1'b0, 1'b1, 8'h00};

    for (int v = 0; v < 5; v++) begin
      crc = vecs[v].use_model ? (model_crc(vecs[v].pkt) ^ {7'b0, vecs[v].tmode}) : vecs[v].crc;
      x0 = xfers;
      push_frame(vecs[v].pkt, crc);
      pulse_start(vecs[v].pkt, vecs[v].tmode);
      chk($sformatf("v%0d_busy", v), 32'(o_busy), 32'd1);
      wait_tx(40, 1'b0, n);
      chk($sformatf("v%0d_cycles", v), 32'(n), 32'(vecs[v].pkt[131:128]) + 32'd2);
      chk($sformatf("v%0d_xfers", v), 32'(xfers - x0), 32'(vecs[v].pkt[131:128]) + 32'd2);
      ack_check($sformatf("v%0d", v), 2'd0);
    end

    // Inputs changed after start must not leak into the frame.
    push_frame(vecs[1].pkt, 8'h14);
    pulse_start(vecs[1].pkt, 1'b1);
    i_tx_packet = '1;
    i_test_mode = 1'b0;
    wait_tx(40, 1'b0, n);
    ack_check("latch", 2'd0);

    // Zero-length frame under a 1/0 ready pattern.
    x0 = xfers;
    push_frame(vecs[3].pkt, 8'h00);
    pulse_start(vecs[3].pkt, 1'b0);
    wait_tx(20, 1'b1, n);
    i_tx_ready = 1'b1;
    chk("stall_xfers", 32'(xfers - x0), 32'd2);
    ack_check("stall", 2'd0);

    // Three NACKs (one as ack+nack together), then silence until timeout.
    d0 = done_cnt; f0 = fail_cnt;
    push_frame(vecs[0].pkt, 8'h15);
    pulse_start(vecs[0].pkt, 1'b0);
    wait_tx(40, 1'b0, n);
    for (int r = 1; r <= 3; r++) begin
      push_frame(vecs[0].pkt, 8'h15);
      tick();
      i_rx_nack = 1'b1;
      i_rx_ack  = (r == 2);
      tick();
      i_rx_nack = 1'b0;
      i_rx_ack  = 1'b0;
      chk($sformatf("nack%0d_retry", r), 32'(o_retry_cnt), 32'(r));
      chk($sformatf("nack%0d_valid", r), 32'(o_tx_valid), 32'd1);
      wait_tx(40, 1'b0, n);
    end
    n = 0;
    while (!o_fail && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_latency", 32'(n), 32'd255);
    chk("timeout_fail", 32'(o_fail), 32'd1);
    chk("timeout_busy", 32'(o_busy), 32'd0);
    chk("timeout_retry", 32'(o_retry_cnt), 32'd3);
    tick();
    chk("fail_pulse", 32'(o_fail), 32'd0);
    repeat (3) tick();
    chk("retry_hold_idle", 32'(o_retry_cnt), 32'd3);
    chk("retry_done_count", 32'(done_cnt - d0), 32'd0);
    chk("retry_fail_count", 32'(fail_cnt - f0), 32'd1);

    // Start and ack during PAY are ignored; reset aborts cleanly.
    d0 = done_cnt; f0 = fail_cnt;
    push_frame(vecs[4].pkt, model_crc(vecs[4].pkt));
    pulse_start(vecs[4].pkt, 1'b0);
    repeat (3) tick();
    i_tx_packet = vecs[0].pkt;
    i_start = 1'b1;
    i_rx_ack = 1'b1;
    tick();
    i_start = 1'b0;
    i_rx_ack = 1'b0;
    tick();
    chk("pay_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    tick();
    chk("abort_valid", 32'(o_tx_valid), 32'd0);
    chk("abort_busy", 32'(o_busy), 32'd0);
    chk("abort_done", 32'(o_done), 32'd0);
    chk("abort_fail", 32'(o_fail), 32'd0);
    chk("abort_retry", 32'(o_retry_cnt), 32'd0);
    exp_q.delete();
    i_rst = 1'b0;
    x0 = xfers;
    repeat (5) tick();
    chk("abort_idle_xfers", 32'(xfers - x0), 32'd0);
    chk("abort_done_count", 32'(done_cnt - d0), 32'd0);
    chk("abort_fail_count", 32'(fail_cnt - f0), 32'd0);

    push_frame(vecs[2].pkt, model_crc(vecs[2].pkt));
    pulse_start(vecs[2].pkt, 1'b0);
    wait_tx(40, 1'b0, n);
    ack_check("recover", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_frame_controller.md
Name: tx_frame_controller

Overview:
Sequences transmission of the 136-bit TX packet built by the front-panel input register onto a byte-wide valid/ready link. It sends the header byte, then the payload bytes up to the header length field, then a CRC-8 byte. It then waits for the receiver's ACK/NACK and retries on NACK or timeout. It sits between the packet input register and the link serializer, and reports busy/done/fail status for LEDs.

Parameters:
MAX_RETRY, 3, retransmissions allowed after the first attempt (0..3; retry counter is 2 bits)
ACK_TIMEOUT, 255, cycles to wait in WAIT_ACK before treating the attempt as failed (1..255)
CRC_POLY, 8'h07, CRC-8 generator polynomial (MSB-first, init 8'h00, no reflection, no final XOR)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle request to send; sampled only in IDLE
tx_packet  input  136  [135:134] dest, [133:132] src, [131:128] length, [127:0] payload with byte 0 at [127:120]
test_mode  input  1  sampled at start; when 1, the transmitted CRC byte is XORed with 8'h01 (error injection)
tx_data  output  8  byte on link
tx_valid  output  1  tx_data valid
tx_ready  input  1  link accepts byte when tx_valid && tx_ready
rx_ack  input  1  receiver positive acknowledge pulse
rx_nack  input  1  receiver negative acknowledge pulse
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse: frame acknowledged
fail  output  1  one-cycle pulse: retries exhausted
retry_cnt  output  2  retransmissions performed for current frame

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE. tx_data=0, tx_valid=0, busy=0, done=0, fail=0, retry_cnt=0, CRC=0, timer=0, byte index=0. Reset mid-frame aborts immediately. No pulse is issued and the link is left idle.
- Synchronous reset applies identically to all internal registers.
- States: IDLE, HDR, PAY, CRC, WAIT_ACK.
- IDLE:
  - On start=1, latch tx_packet and test_mode into internal copies. Later input changes do not affect the frame.
  - Clear retry_cnt, then go to HDR.
  - start in any other state is ignored.
- HDR:
  - tx_valid=1, tx_data=latched[135:128].
  - On transfer, fold the byte into the CRC and set index=0.
  - If length==0 go to CRC, else go to PAY.
- PAY:
  - tx_data=latched[127-8*index -: 8].
  - On transfer, fold into CRC and increment index.
  - When index+1==length, go to CRC.
  - Length is 1..15, so index never exceeds 14; byte 15 ([7:0]) is never sent.
- CRC:
  - tx_data = crc ^ {7'b0, test_mode_latched}.
  - On transfer, clear the timer and go to WAIT_ACK.
- Link handshake:
  - tx_valid is asserted in HDR/PAY/CRC and deasserted in all other states.
  - tx_data is held stable while tx_valid && !tx_ready.
  - At most one byte transfers per cycle.
  - Back-to-back transfers are possible with zero bubble cycles: a frame of L payload bytes takes L+2 cycles with tx_ready held high.
- CRC computation: 8 shift/XOR steps per byte, combinational, registered on the transfer edge. The CRC restarts at 8'h00 on every (re)transmission.
- WAIT_ACK:
  - The timer increments each cycle.
  - rx_nack=1, or timer==ACK_TIMEOUT-1 with no ack: if retry_cnt<MAX_RETRY, increment retry_cnt, reset CRC and index, and go to HDR (resend the latched frame). Otherwise pulse fail and go to IDLE.
  - rx_ack=1 (and rx_nack=0): pulse done and go to IDLE.
  - rx_ack and rx_nack in the same cycle is treated as NACK.
  - ack/nack arriving outside WAIT_ACK is ignored.
  - An ack and a timeout in the same cycle resolve as ack.
- done and fail are registered, high for exactly the cycle after the deciding edge, and never high together.
- busy goes low in the same cycle done/fail is high.
- retry_cnt holds its value in IDLE until the next start.

Test Plan:
1. Header 8'h01 (len 1), payload byte 8'h00, test_mode=0, tx_ready=1 -> bytes 01,00,15 on consecutive cycles; rx_ack 2 cycles later -> done pulse, retry_cnt=0.
2. Same frame with test_mode=1 -> CRC byte 8'h14. Then change tx_packet/test_mode mid-frame -> transmitted bytes unchanged.
3. Header 8'h00 (len 0) -> header 00 then CRC 00, no payload. Toggle tx_ready 1/0 every cycle -> tx_data stable while stalled, exactly 2 transfers.
4. Header 8'h4F (len 15), payload 0x00..0x0E -> 17 transfers, last payload 0x0E, bits [7:0] never sent. CRC matches the bench model.
5. Scenario 1 frame, answer NACK 3 times, then no reply -> 4 attempts, retry_cnt=3, fail pulse ACK_TIMEOUT cycles after the 4th CRC. Same cycle ack+nack counts as NACK.
6. Assert rst during PAY -> next cycle tx_valid=0, busy=0, no done/fail. A start pulse while busy is ignored.
